// File: rtl/bichito_motion.sv
`default_nettype none
// ============================================================================
//  Module      : bichito_motion
//  Description : Vertical-motion controller for the player sprite. Owns the
//                sprite Y position, applies per-frame gravity and jump
//                impulses, clamps at the screen top, detects the floor and
//                runs the IDLE / FLYING / DEAD play-state machine. Position
//                only changes on frame_tick so the sprite never moves
//                mid-scan.
//
//  Ports       : clk        - system (pixel) clock
//                rst_n      - asynchronous active-low reset
//                frame_tick - one-cycle pulse per frame (vertical blank)
//                jump_btn   - jump button level, synchronous to clk
//                collision  - high while the sprite overlaps an obstacle
//                currY      - sprite top Y, bits [31:10] always zero
//                vel        - current signed velocity (debug / HUD)
//                state      - 0 = IDLE, 1 = FLYING, 2 = DEAD
//                dead       - high iff state == DEAD
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bichito_motion #(
    parameter logic        [9:0] BASE_YPOS = 10'd240,
    parameter logic        [9:0] Y_MIN     = 10'd0,
    parameter logic        [9:0] Y_MAX     = 10'd464,
    parameter logic signed [7:0] GRAVITY   = 8'sd1,
    parameter logic signed [7:0] JUMP_VEL  = -8'sd6,
    parameter logic signed [7:0] MAX_FALL  = 8'sd8,
    parameter logic        [7:0] DEAD_HOLD = 8'd30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        jump_btn,
    input  logic        collision,
    output logic [31:0] currY,
    output logic [7:0]  vel,
    output logic [1:0]  state,
    output logic        dead
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FLYING = 2'd1;
    localparam logic [1:0] c_DEAD   = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [9:0]        r_y;
    logic [9:0]        w_y_next;
    logic signed [7:0] r_vel;
    logic signed [7:0] w_vel_next;
    logic              r_jump_pending;
    logic              w_jump_pending_next;
    logic [7:0]        r_hold_cnt;
    logic [7:0]        w_hold_cnt_next;
    logic              r_btn_q;
    logic              r_dead;

    // ------------------------------------------------------------------
    // Button edge detect
    // ------------------------------------------------------------------
    logic w_rise;
    assign w_rise = jump_btn & ~r_btn_q;

    // ------------------------------------------------------------------
    // Physics step for one frame in FLYING
    // ------------------------------------------------------------------
    logic               w_jump_now;
    logic signed [8:0]  w_vel_grav;
    logic signed [8:0]  w_max_fall_w;
    logic signed [7:0]  w_vel_fall;
    logic signed [7:0]  w_vel_step;
    logic signed [11:0] w_y_step;
    logic               w_top_hit;
    logic               w_floor_hit;

    // A rise coinciding with the tick still counts for this frame.
    assign w_jump_now = r_jump_pending | w_rise;

    // Nine bits so vel + GRAVITY cannot wrap before the terminal clamp.
    assign w_vel_grav   = $signed({r_vel[7], r_vel}) + $signed({GRAVITY[7], GRAVITY});
    assign w_max_fall_w = $signed({MAX_FALL[7], MAX_FALL});
    assign w_vel_fall   = (w_vel_grav > w_max_fall_w) ? MAX_FALL : w_vel_grav[7:0];
    assign w_vel_step   = w_jump_now ? JUMP_VEL : w_vel_fall;

    // Y is unsigned, so zero-extend it; velocity is sign-extended.
    assign w_y_step    = $signed({2'b00, r_y}) + $signed({{4{w_vel_step[7]}}, w_vel_step});
    assign w_top_hit   = w_y_step <  $signed({2'b00, Y_MIN});
    assign w_floor_hit = w_y_step >= $signed({2'b00, Y_MAX});

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_rise) begin
                    w_state_next = c_FLYING;
                end
            end
            c_FLYING: begin
                // Collision wins over a simultaneous frame tick.
                if (collision) begin
                    w_state_next = c_DEAD;
                end else if (frame_tick && !w_top_hit && w_floor_hit) begin
                    w_state_next = c_DEAD;
                end
            end
            c_DEAD: begin
                if (w_rise && (r_hold_cnt == DEAD_HOLD)) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: datapath / output next values
    // ------------------------------------------------------------------
    always_comb begin
        w_y_next            = r_y;
        w_vel_next          = r_vel;
        w_jump_pending_next = r_jump_pending;
        w_hold_cnt_next     = r_hold_cnt;
        case (r_state)
            c_IDLE: begin
                w_y_next            = BASE_YPOS;
                w_vel_next          = 8'sd0;
                w_hold_cnt_next     = 8'd0;
                // The start press doubles as the first jump.
                w_jump_pending_next = w_rise;
            end
            c_FLYING: begin
                if (collision) begin
                    // Freeze position and velocity where the hit happened.
                    w_jump_pending_next = 1'b0;
                    w_hold_cnt_next     = 8'd0;
                end else if (frame_tick) begin
                    w_jump_pending_next = 1'b0;
                    if (w_top_hit) begin
                        w_y_next   = Y_MIN;
                        w_vel_next = 8'sd0;
                    end else if (w_floor_hit) begin
                        w_y_next        = Y_MAX;
                        w_vel_next      = 8'sd0;
                        w_hold_cnt_next = 8'd0;
                    end else begin
                        w_y_next   = w_y_step[9:0];
                        w_vel_next = w_vel_step;
                    end
                end else if (w_rise) begin
                    w_jump_pending_next = 1'b1;
                end
            end
            c_DEAD: begin
                w_jump_pending_next = 1'b0;
                if (w_rise && (r_hold_cnt == DEAD_HOLD)) begin
                    w_y_next        = BASE_YPOS;
                    w_vel_next      = 8'sd0;
                    w_hold_cnt_next = 8'd0;
                end else if (frame_tick && (r_hold_cnt < DEAD_HOLD)) begin
                    w_hold_cnt_next = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_y_next            = BASE_YPOS;
                w_vel_next          = 8'sd0;
                w_jump_pending_next = 1'b0;
                w_hold_cnt_next     = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y            <= BASE_YPOS;
            r_vel          <= 8'sd0;
            r_jump_pending <= 1'b0;
            r_hold_cnt     <= 8'd0;
            r_btn_q        <= 1'b0;
            r_dead         <= 1'b0;
        end else begin
            r_y            <= w_y_next;
            r_vel          <= w_vel_next;
            r_jump_pending <= w_jump_pending_next;
            r_hold_cnt     <= w_hold_cnt_next;
            r_btn_q        <= jump_btn;
            r_dead         <= (w_state_next == c_DEAD);
        end
    end

    assign currY = {22'd0, r_y};
    assign vel   = r_vel;
    assign state = r_state;
    assign dead  = r_dead;

endmodule
`default_nettype wire

// File: tb/tb_bichito_motion.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bichito_motion
//  Description : Directed self-checking bench for bichito_motion. Inputs are
//                driven and outputs sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bichito_motion;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        jump_btn;
    logic        collision;
    logic [31:0] currY;
    logic [7:0]  vel;
    logic [1:0]  state;
    logic        dead;

    int n_pass;
    int n_total;

    bichito_motion dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .jump_btn   (jump_btn),
        .collision  (collision),
        .currY      (currY),
        .vel        (vel),
        .state      (state),
        .dead       (dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
        n_total++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // One frame tick, no button.
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // One-cycle button pulse, no tick.
    task automatic press();
        @(negedge clk);
        jump_btn = 1'b1;
        @(negedge clk);
        jump_btn = 1'b0;
    endtask

    // Button rise in the same cycle as the frame tick.
    task automatic tick_jump();
        @(negedge clk);
        frame_tick = 1'b1;
        jump_btn   = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        jump_btn   = 1'b0;
    endtask

    task automatic chk_pos(input string tag, input int y, input int v, input int st);
        chk({tag, "_y"},     $signed(currY),        y);
        chk({tag, "_vel"},   $signed(vel),          v);
        chk({tag, "_state"}, $signed({30'd0, state}), st);
    endtask

    int exp_y3[3]  = '{234, 229, 225};
    int exp_v3[3]  = '{-6, -5, -4};
    int exp_y13[13] = '{222, 220, 219, 219, 220, 222, 225, 229, 234, 240, 247, 255, 263};
    int exp_v13[13] = '{-3, -2, -1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 8};

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        jump_btn   = 1'b0;
        collision  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk_pos("rst", 240, 0, 0);
        chk("rst_dead", {31'd0, dead}, 0);
        chk("rst_hi", {10'd0, currY[31:10]}, 0);

        // IDLE ignores frame ticks
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_pos("idle", 240, 0, 0);
        end
        chk("idle_hi", {10'd0, currY[31:10]}, 0);

        // Start press is also the first jump
        press();
        chk("start_state", {30'd0, state}, 1);
        chk("start_y", $signed(currY), 240);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_pos("jump", exp_y3[i], exp_v3[i], 1);
        end

        // Gravity up to terminal velocity
        for (int i = 0; i < 13; i++) begin
            tick();
            chk_pos("grav", exp_y13[i], exp_v13[i], 1);
        end

        // Climb to the top: 43 jumps of -6 from 263 ends at 5
        for (int i = 0; i < 43; i++) begin
            if (i % 2 == 0) begin
                tick_jump();
            end else begin
                press();
                tick();
            end
        end
        chk_pos("climb", 5, -6, 1);
        tick_jump();
        chk_pos("topclamp", 0, 0, 1);

        // Fall from the top: 8 ticks reach terminal velocity at y=36
        repeat (8) tick();
        chk_pos("fall8", 36, 8, 1);
        repeat (53) tick();
        chk_pos("fall61", 460, 8, 1);
        chk("fall_dead", {31'd0, dead}, 0);
        tick();
        chk_pos("floor", 464, 0, 2);
        chk("floor_dead", {31'd0, dead}, 1);

        // Restart hold-off
        repeat (10) tick();
        press();
        chk_pos("hold10", 464, 0, 2);
        repeat (19) tick();
        press();
        chk_pos("hold29", 464, 0, 2);
        tick();
        chk_pos("hold30", 464, 0, 2);
        press();
        chk_pos("restart", 240, 0, 0);
        chk("restart_dead", {31'd0, dead}, 0);
        tick();
        chk_pos("restart_idle", 240, 0, 0);

        // Double press in one frame is a single jump
        press();
        press();
        tick();
        chk_pos("dbl", 234, -6, 1);
        repeat (9) tick();
        chk_pos("pre_coll", 225, 3, 1);

        // Collision with simultaneous tick: frozen, no update
        @(negedge clk);
        collision  = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        collision  = 1'b0;
        frame_tick = 1'b0;
        chk_pos("coll", 225, 3, 2);
        chk("coll_dead", {31'd0, dead}, 1);
        tick();
        chk_pos("coll_frozen", 225, 3, 2);

        // Asynchronous reset while DEAD
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_pos("async_rst", 240, 0, 0);
        chk("async_rst_dead", {31'd0, dead}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Collision ignored in IDLE
        @(negedge clk);
        collision  = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        collision  = 1'b0;
        frame_tick = 1'b0;
        chk_pos("idle_coll", 240, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bichito_motion.md
Name: bichito_motion

Overview:
- Vertical-motion controller for the player sprite: owns the sprite's Y position and drives the sprite renderer's 32-bit currY input.
- Applies per-frame gravity and jump impulses, clamps at the screen top, and detects the floor.
- Runs a play-state FSM (IDLE/FLYING/DEAD) that the game top uses for scoring and pipe logic.
- Updates once per video frame on frame_tick, so the sprite never moves mid-scan.

Parameters:
BASE_YPOS, 10'd240, Y loaded at reset and on re-entering IDLE
Y_MIN, 10'd0, top clamp
Y_MAX, 10'd464, floor; screen height 480 minus sprite height 16
GRAVITY, 8'sd1, velocity increment per frame, px/frame^2
JUMP_VEL, -8'sd6, velocity loaded on jump (negative = up)
MAX_FALL, 8'sd8, terminal downward velocity
DEAD_HOLD, 8'd30, frames in DEAD before a restart press is accepted

Ports:
clk  in  1  system clock (pixel clock domain)
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame, at start of vertical blank
jump_btn  in  1  jump button level, already synchronized to clk
collision  in  1  level; high when the sprite overlaps an obstacle
currY  out  32  sprite top Y; bits [31:10] are always 0
vel  out  8  current signed velocity, for debug/HUD
state  out  2  0=IDLE, 1=FLYING, 2=DEAD
dead  out  1  high iff state==DEAD

Behaviour:
- Reset (async, rst_n=0):
  - y=BASE_YPOS, vel=0, state=IDLE, dead=0.
  - jump_pending=0, hold_cnt=0, btn_q=0.
  - All outputs are registered.
- Edge detect:
  - btn_q <= jump_btn each cycle; rise = jump_btn & ~btn_q.
  - In FLYING, a rise sets jump_pending.
  - jump_pending clears on the frame_tick that consumes it.
  - Multiple rises within one frame produce a single jump.
- IDLE:
  - y held at BASE_YPOS, vel=0; frame_tick has no effect.
  - A rise moves to FLYING and sets jump_pending, so the start press is also the first jump.
- FLYING, on frame_tick (results visible the following cycle):
  - If jump_pending: vel_n = JUMP_VEL. Otherwise vel_n = min(vel+GRAVITY, MAX_FALL), computed signed.
  - y_n = y + vel_n, computed in 12-bit signed arithmetic (y zero-extended).
  - If y_n < Y_MIN: y=Y_MIN, vel=0.
  - Else if y_n >= Y_MAX: y=Y_MAX, vel=0, go to DEAD, hold_cnt=0.
  - Else: y=y_n, vel=vel_n.
  - A rise in the same cycle as frame_tick counts for that frame.
- FLYING, collision=1:
  - Go to DEAD on the next edge with y and vel frozen, hold_cnt=0.
  - Collision has priority over a simultaneous frame_tick: no position update that frame.
- DEAD:
  - y and vel frozen; jump_pending forced to 0.
  - Each frame_tick increments hold_cnt, saturating at DEAD_HOLD.
  - A rise while hold_cnt < DEAD_HOLD is ignored.
  - A rise with hold_cnt == DEAD_HOLD goes to IDLE with y=BASE_YPOS, vel=0. That press does not also start a flight.
- collision is ignored in IDLE and DEAD.
- Reset asserted mid-frame or mid-DEAD returns all state immediately to reset values.

Test Plan:
- Reset, then 5 frame_ticks with no input -> currY=240, state=0, vel=0 throughout; currY[31:10]=0.
- From IDLE, pulse jump_btn, then 3 frame_ticks -> state=1; (vel,currY) = (-6,234), (-5,229), (-4,225).
- FLYING at y=240, vel=0, no jump, 10 frame_ticks -> vel 1..8 then held at 8; y after each tick: 241, 243, 246, 250, 255, 261, 268, 276, 284, 292.
- Top clamp: y=3, vel=0, jump then frame_tick -> y=0, vel=0, state stays 1.
- Floor: y=460, vel=8, frame_tick -> y=464, state=2, dead=1. Jump after 10 ticks ignored. Jump after 30 ticks -> next cycle state=0, currY=240.
- collision and frame_tick in the same cycle at y=300, vel=3 -> state=2, y=300, vel=3 (no update). Reset pulse during DEAD -> state=0, currY=240 asynchronously.
